// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_pkg
// Description : Shared encodings for the RISC CPU control FSM: state codes,
//               memory commands, register-select and writeback-select
//               constants, and instruction opcode/op fields.
// Revision    : 1.0 - initial release
// ============================================================================
package fsm_pkg;

    // Controller state encodings (4-bit)
    localparam logic [3:0] c_ST_RESET   = 4'b0000;
    localparam logic [3:0] c_ST_DECODE  = 4'b0001;
    localparam logic [3:0] c_ST_GETA    = 4'b0010;
    localparam logic [3:0] c_ST_GETB    = 4'b0011;
    localparam logic [3:0] c_ST_EXECUTE = 4'b0100;
    localparam logic [3:0] c_ST_STORE   = 4'b0101;
    localparam logic [3:0] c_ST_RD1     = 4'b0110;
    localparam logic [3:0] c_ST_RD2     = 4'b0111;
    localparam logic [3:0] c_ST_UPDPC   = 4'b1000;
    localparam logic [3:0] c_ST_HALT    = 4'b1001;
    localparam logic [3:0] c_ST_LDADDR  = 4'b1010;
    localparam logic [3:0] c_ST_RDLDR   = 4'b1011;
    localparam logic [3:0] c_ST_EXSTR   = 4'b1100;
    localparam logic [3:0] c_ST_WRMEM   = 4'b1101;

    // Memory commands
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    // One-hot register-file selects
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    // Writeback source selects
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    // Instruction opcode field IR[15:13]
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // Instruction op field IR[12:11]
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ALU_CMP = 2'b01;

endpackage : fsm_pkg
`default_nettype wire

// File: rtl/fsm_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : fsm_controller_if
// Description : Control bundle between the CPU controller and the datapath.
//               master : controller (drives controls, reads IR fields)
//               slave  : datapath/memory side (drives IR fields, reads controls)
// Ports       : opcode[2:0], op[1:0]        - IR fields into the controller
//               nsel, asel, bsel, vsel,     - datapath controls
//               loada/b/c, loads, write_regfile
//               load_pc, reset_pc,          - PC / address controls
//               load_addr, addr_sel
//               mem_cmd[1:0], load_ir       - memory / IR controls
// Revision    : 1.0 - initial release
// ============================================================================
interface fsm_controller_if;

    logic [2:0] opcode;
    logic [1:0] op;

    logic [2:0] nsel;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write_regfile;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       load_ir;

    modport master (
        input  opcode, op,
        output nsel, asel, bsel, vsel, loada, loadb, loadc, loads,
               write_regfile, load_pc, reset_pc, load_addr, addr_sel,
               mem_cmd, load_ir
    );

    modport slave (
        output opcode, op,
        input  nsel, asel, bsel, vsel, loada, loadb, loadc, loads,
               write_regfile, load_pc, reset_pc, load_addr, addr_sel,
               mem_cmd, load_ir
    );

endinterface : fsm_controller_if
`default_nettype wire

// File: rtl/fsm_controller.sv
`default_nettype none
// ============================================================================
// Module      : fsm_controller
// Description : Moore control FSM for the simple RISC CPU. Sequences fetch
//               (RD1, RD2, UPDPC), decode and execution of MOV, ALU, LDR,
//               STR and HALT instructions.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous, active-low reset
//               bus   - fsm_controller_if.master: IR fields in, controls out
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_controller
    import fsm_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          reset,
    fsm_controller_if.master   bus
);

    logic [3:0] r_state;
    logic [3:0] w_state_nxt;

    // Instruction class decode from the current IR fields
    logic w_is_alu;
    logic w_is_cmp;
    logic w_is_movi;
    logic w_is_movr;
    logic w_is_ldr;
    logic w_is_str;
    logic w_is_halt;

    assign w_is_alu  = (bus.opcode == OPC_ALU);
    assign w_is_cmp  = w_is_alu && (bus.op == OP_ALU_CMP);
    assign w_is_movi = (bus.opcode == OPC_MOV) && (bus.op == OP_MOV_IMM);
    assign w_is_movr = (bus.opcode == OPC_MOV) && (bus.op == OP_MOV_REG);
    assign w_is_ldr  = (bus.opcode == OPC_LDR);
    assign w_is_str  = (bus.opcode == OPC_STR);
    assign w_is_halt = (bus.opcode == OPC_HALT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Instruction-dependent states fall back to RD1 if
    // the IR fields do not match any class, so a corrupted IR cannot wedge
    // the controller.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = c_ST_RESET;
        case (r_state)
            c_ST_RESET:  w_state_nxt = c_ST_RD1;
            c_ST_RD1:    w_state_nxt = c_ST_RD2;
            c_ST_RD2:    w_state_nxt = c_ST_UPDPC;
            c_ST_UPDPC:  w_state_nxt = c_ST_DECODE;
            c_ST_DECODE: begin
                if (w_is_halt)                           w_state_nxt = c_ST_HALT;
                else if (w_is_movi)                      w_state_nxt = c_ST_STORE;
                else if (w_is_movr)                      w_state_nxt = c_ST_GETB;
                else if (w_is_alu || w_is_ldr || w_is_str) w_state_nxt = c_ST_GETA;
                else                                     w_state_nxt = c_ST_RD1;
            end
            c_ST_GETA: begin
                if (w_is_alu)                   w_state_nxt = c_ST_GETB;
                else if (w_is_ldr || w_is_str)  w_state_nxt = c_ST_EXECUTE;
                else                            w_state_nxt = c_ST_RD1;
            end
            c_ST_GETB: begin
                if (w_is_alu || w_is_movr)  w_state_nxt = c_ST_EXECUTE;
                else if (w_is_str)          w_state_nxt = c_ST_EXSTR;
                else                        w_state_nxt = c_ST_RD1;
            end
            c_ST_EXECUTE: begin
                if (w_is_cmp)                   w_state_nxt = c_ST_RD1;
                else if (w_is_alu || w_is_movr) w_state_nxt = c_ST_STORE;
                else if (w_is_ldr || w_is_str)  w_state_nxt = c_ST_LDADDR;
                else                            w_state_nxt = c_ST_RD1;
            end
            c_ST_LDADDR: begin
                if (w_is_ldr)       w_state_nxt = c_ST_RDLDR;
                else if (w_is_str)  w_state_nxt = c_ST_GETB;
                else                w_state_nxt = c_ST_RD1;
            end
            c_ST_RDLDR:  w_state_nxt = c_ST_STORE;
            c_ST_STORE:  w_state_nxt = c_ST_RD1;
            c_ST_EXSTR:  w_state_nxt = c_ST_WRMEM;
            c_ST_WRMEM:  w_state_nxt = c_ST_RD1;
            c_ST_HALT:   w_state_nxt = c_ST_HALT;
            default:     w_state_nxt = c_ST_RESET;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore: state plus the held IR fields)
    // ------------------------------------------------------------------
    always_comb begin
        bus.nsel          = NSEL_NONE;
        bus.asel          = 1'b0;
        bus.bsel          = 1'b0;
        bus.vsel          = VSEL_C;
        bus.loada         = 1'b0;
        bus.loadb         = 1'b0;
        bus.loadc         = 1'b0;
        bus.loads         = 1'b0;
        bus.write_regfile = 1'b0;
        bus.load_pc       = 1'b0;
        bus.reset_pc      = 1'b0;
        bus.load_addr     = 1'b0;
        bus.addr_sel      = 1'b0;
        bus.mem_cmd       = MNONE;
        bus.load_ir       = 1'b0;

        case (r_state)
            c_ST_RESET: begin
                bus.load_pc  = 1'b1;
                bus.reset_pc = 1'b1;
            end
            c_ST_RD1: begin
                bus.mem_cmd  = MREAD;
                bus.addr_sel = 1'b1;
            end
            c_ST_RD2: begin
                bus.mem_cmd  = MREAD;
                bus.addr_sel = 1'b1;
                bus.load_ir  = 1'b1;
            end
            c_ST_UPDPC: begin
                bus.load_pc = 1'b1;
            end
            c_ST_GETA: begin
                bus.nsel  = NSEL_RN;
                bus.loada = 1'b1;
            end
            c_ST_GETB: begin
                if (w_is_alu || w_is_movr) begin
                    bus.nsel  = NSEL_RM;
                    bus.loadb = 1'b1;
                end else if (w_is_str) begin
                    // STR reads the data to store from Rd
                    bus.nsel  = NSEL_RD;
                    bus.loadb = 1'b1;
                end
            end
            c_ST_EXECUTE: begin
                bus.loadc = 1'b1;
                bus.asel  = w_is_movr;
                bus.bsel  = w_is_ldr || w_is_str;
                bus.loads = w_is_cmp;
            end
            c_ST_LDADDR: begin
                bus.load_addr = 1'b1;
            end
            c_ST_RDLDR: begin
                bus.mem_cmd = MREAD;
            end
            c_ST_STORE: begin
                bus.write_regfile = 1'b1;
                if (w_is_movi) begin
                    bus.vsel = VSEL_IMM8;
                    bus.nsel = NSEL_RN;
                end else if (w_is_ldr) begin
                    // Keep the read active so mdata is still valid at writeback
                    bus.vsel    = VSEL_MDATA;
                    bus.nsel    = NSEL_RD;
                    bus.mem_cmd = MREAD;
                end else begin
                    bus.vsel = VSEL_C;
                    bus.nsel = NSEL_RD;
                end
            end
            c_ST_EXSTR: begin
                // Pass B (Rd data) through the ALU with A forced to 0
                bus.loadc = 1'b1;
                bus.asel  = 1'b1;
            end
            c_ST_WRMEM: begin
                bus.mem_cmd = MWRITE;
            end
            default: begin
                // DECODE, HALT and unused codes assert nothing
            end
        endcase
    end

endmodule : fsm_controller
`default_nettype wire

// File: tb/tb_fsm_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_controller
// Description : Directed self-checking bench for fsm_controller. Walks the
//               controller through fetch, each instruction class, HALT and
//               asynchronous reset, comparing the packed control vector
//               against hand-written expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_controller;

    // Packed control vector layout:
    // [18:16] nsel [15] asel [14] bsel [13:12] vsel [11] loada [10] loadb
    // [9] loadc [8] loads [7] write_regfile [6] load_pc [5] reset_pc
    // [4] load_addr [3] addr_sel [2:1] mem_cmd [0] load_ir
    localparam logic [18:0] c_N_RN  = 19'h1 << 18;
    localparam logic [18:0] c_N_RD  = 19'h1 << 17;
    localparam logic [18:0] c_N_RM  = 19'h1 << 16;
    localparam logic [18:0] c_ASEL  = 19'h1 << 15;
    localparam logic [18:0] c_BSEL  = 19'h1 << 14;
    localparam logic [18:0] c_V_IMM = 19'h2 << 12;
    localparam logic [18:0] c_V_MD  = 19'h3 << 12;
    localparam logic [18:0] c_LA    = 19'h1 << 11;
    localparam logic [18:0] c_LB    = 19'h1 << 10;
    localparam logic [18:0] c_LC    = 19'h1 << 9;
    localparam logic [18:0] c_LS    = 19'h1 << 8;
    localparam logic [18:0] c_WR    = 19'h1 << 7;
    localparam logic [18:0] c_LPC   = 19'h1 << 6;
    localparam logic [18:0] c_RPC   = 19'h1 << 5;
    localparam logic [18:0] c_LADDR = 19'h1 << 4;
    localparam logic [18:0] c_ASL   = 19'h1 << 3;
    localparam logic [18:0] c_M_RD  = 19'h1 << 1;
    localparam logic [18:0] c_M_WR  = 19'h2 << 1;
    localparam logic [18:0] c_LIR   = 19'h1;
    localparam logic [18:0] c_NONE  = 19'h0;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    fsm_controller_if bus_if ();

    fsm_controller u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [18:0] expected);
        logic [18:0] observed;
        observed = {bus_if.nsel, bus_if.asel, bus_if.bsel, bus_if.vsel,
                    bus_if.loada, bus_if.loadb, bus_if.loadc, bus_if.loads,
                    bus_if.write_regfile, bus_if.load_pc, bus_if.reset_pc,
                    bus_if.load_addr, bus_if.addr_sel, bus_if.mem_cmd,
                    bus_if.load_ir};
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s observed %05h expected %05h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously, check RESET outputs, release at negedge
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk(tag, c_LPC | c_RPC);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // RD1 -> RD2 -> UPDPC -> DECODE, loading the instruction fields in RD1
    task automatic fetch(input string tag, input logic [2:0] opc, input logic [1:0] opf);
        tick();
        chk({tag, "_rd1"}, c_M_RD | c_ASL);
        bus_if.opcode = opc;
        bus_if.op     = opf;
        tick();
        chk({tag, "_rd2"}, c_M_RD | c_ASL | c_LIR);
        tick();
        chk({tag, "_updpc"}, c_LPC);
        tick();
        chk({tag, "_decode"}, c_NONE);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        bus_if.opcode = 3'b000;
        bus_if.op     = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", c_LPC | c_RPC);
        do_reset("reset_init");

        // ADD: GETA, GETB, EXECUTE, STORE
        fetch("add", 3'b101, 2'b00);
        tick(); chk("add_geta",    c_N_RN | c_LA);
        tick(); chk("add_getb",    c_N_RM | c_LB);
        tick(); chk("add_execute", c_LC);
        tick(); chk("add_store",   c_WR | c_N_RD);

        // LDR: GETA, EXECUTE, LDADDR, RDLDR, STORE
        fetch("ldr", 3'b011, 2'b00);
        tick(); chk("ldr_geta",    c_N_RN | c_LA);
        tick(); chk("ldr_execute", c_LC | c_BSEL);
        tick(); chk("ldr_ldaddr",  c_LADDR);
        tick(); chk("ldr_rdldr",   c_M_RD);
        tick(); chk("ldr_store",   c_WR | c_V_MD | c_N_RD | c_M_RD);

        // STR: GETA, EXECUTE, LDADDR, GETB, EXSTR, WRMEM
        fetch("str", 3'b100, 2'b00);
        tick(); chk("str_geta",    c_N_RN | c_LA);
        tick(); chk("str_execute", c_LC | c_BSEL);
        tick(); chk("str_ldaddr",  c_LADDR);
        tick(); chk("str_getb",    c_N_RD | c_LB);
        tick(); chk("str_exstr",   c_LC | c_ASEL);
        tick(); chk("str_wrmem",   c_M_WR);

        // MOV immediate: DECODE straight to STORE
        fetch("movi", 3'b110, 2'b10);
        tick(); chk("movi_store", c_WR | c_V_IMM | c_N_RN);

        // MOV register: GETB, EXECUTE with A forced to 0, STORE
        fetch("movr", 3'b110, 2'b00);
        tick(); chk("movr_getb",    c_N_RM | c_LB);
        tick(); chk("movr_execute", c_LC | c_ASEL);
        tick(); chk("movr_store",   c_WR | c_N_RD);

        // CMP: loads status, returns to RD1 without a writeback
        fetch("cmp", 3'b101, 2'b01);
        tick(); chk("cmp_geta",    c_N_RN | c_LA);
        tick(); chk("cmp_getb",    c_N_RM | c_LB);
        tick(); chk("cmp_execute", c_LC | c_LS);

        // Unrecognised opcode: DECODE back to RD1
        fetch("nop", 3'b000, 2'b11);

        // Reset asserted mid-instruction during EXECUTE
        fetch("abort", 3'b101, 2'b00);
        tick(); chk("abort_geta",    c_N_RN | c_LA);
        tick(); chk("abort_getb",    c_N_RM | c_LB);
        tick(); chk("abort_execute", c_LC);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_async_reset", c_LPC | c_RPC);
        tick();
        chk("abort_reset_held", c_LPC | c_RPC);
        @(negedge clk);
        reset = 1'b1;

        // HALT: stays put with every output low until reset
        fetch("halt", 3'b111, 2'b00);
        tick(); chk("halt_0", c_NONE);
        tick(); chk("halt_1", c_NONE);
        tick(); chk("halt_2", c_NONE);
        tick(); chk("halt_3", c_NONE);
        #2;
        do_reset("halt_reset");

        // Recovery after HALT: a normal fetch resumes
        fetch("recover", 3'b110, 2'b10);
        tick(); chk("recover_store", c_WR | c_V_IMM | c_N_RN);
        tick(); chk("recover_rd1",   c_M_RD | c_ASL);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fsm_controller
`default_nettype wire
